// File: rtl/filter_coef_sequencer.sv
// filter_coef_sequencer
//   Steers a stream of 32-bit coefficient words into the LPF_X, LPF_Y and
//   Hilbert FIRs (in that order). After loading, it pulses clr to flush the
//   filter state, then lets samples through by dropping stall in RUN.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         request a (re)load; honoured in IDLE and RUN only
//   abort         abandon any load and return to IDLE (beats start/accept)
//   coef_data     coefficient word, accepted when coef_valid && coef_ready
//   coef_valid    coef_data is valid
//   coef_ready    high in the three LOAD states
//   sample_valid  upstream sample present
//   cr            registered coefficient bus to the filter bank
//   we_lpf_x/_y   one-cycle write strobes, one cycle after the accept
//   we_htf        Hilbert write strobe, one cycle after the accept
//   clr           held for CLR_CYCLES cycles right after the last we_htf
//   stall         low only in RUN while sample_valid is high
//   busy          high in every state except IDLE and RUN
//   done          one-cycle pulse on the first RUN cycle
module filter_coef_sequencer #(
  parameter int LPF_TAP    = 32,
  parameter int HPF_TAP    = 96,
  parameter int CNT_W      = 8,
  parameter int CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] coef_data,
  input  logic        coef_valid,
  output logic        coef_ready,
  input  logic        sample_valid,
  output logic [31:0] cr,
  output logic        we_lpf_x,
  output logic        we_lpf_y,
  output logic        we_htf,
  output logic        clr,
  output logic        stall,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_LOAD_Y = 3'd2,
    ST_LOAD_H = 3'd3,
    ST_CLR    = 3'd4,
    ST_RUN    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LPF_LAST = CNT_W'(LPF_TAP - 1);
  localparam logic [CNT_W-1:0] HPF_LAST = CNT_W'(HPF_TAP - 1);
  // In CLR the counter spans the we_htf cycle plus CLR_CYCLES clr cycles.
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             accept_s;
  logic [31:0]      cr_r;
  logic             we_x_r, we_y_r, we_h_r, clr_r, done_r;

  // Handshake and status outputs decoded straight from the state register.
  always_comb begin
    coef_ready = 1'b0;
    busy       = 1'b0;
    stall      = 1'b1;
    case (state_r)
      ST_LOAD_X, ST_LOAD_Y, ST_LOAD_H: begin
        coef_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_CLR: begin
        busy = 1'b1;
      end
      ST_RUN: begin
        stall = ~sample_valid;
      end
      default: begin
        coef_ready = 1'b0;
      end
    endcase
  end

  // Next-state and counter logic; abort overrides everything else.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = coef_valid & coef_ready & ~abort;
    if (abort) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            state_s = ST_LOAD_X;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = state_r;
          end
        end
        ST_LOAD_X, ST_LOAD_Y: begin
          if (accept_s && (cnt_r == LPF_LAST)) begin
            state_s = (state_r == ST_LOAD_X) ? ST_LOAD_Y : ST_LOAD_H;
            cnt_s   = CNT_ZERO;
          end else if (accept_s) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_LOAD_H: begin
          if (accept_s && (cnt_r == HPF_LAST)) begin
            state_s = ST_CLR;
            cnt_s   = CNT_ZERO;
          end else if (accept_s) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_CLR: begin
          if (cnt_r == CLR_LAST) begin
            state_s = ST_RUN;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and registered filter-bank strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      cr_r    <= 32'h0000_0000;
      we_x_r  <= 1'b0;
      we_y_r  <= 1'b0;
      we_h_r  <= 1'b0;
      clr_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        cr_r <= coef_data;
      end
      we_x_r <= accept_s & (state_r == ST_LOAD_X);
      we_y_r <= accept_s & (state_r == ST_LOAD_Y);
      we_h_r <= accept_s & (state_r == ST_LOAD_H);
      // The first CLR cycle carries the final we_htf, so clr starts one later.
      clr_r  <= ~abort & (state_r == ST_CLR) & (cnt_r != CLR_LAST);
      done_r <= (state_s == ST_RUN) & (state_r != ST_RUN);
    end
  end

  assign cr       = cr_r;
  assign we_lpf_x = we_x_r;
  assign we_lpf_y = we_y_r;
  assign we_htf   = we_h_r;
  assign clr      = clr_r;
  assign done     = done_r;

endmodule

// File: tb/tb_filter_coef_sequencer.sv
module tb_filter_coef_sequencer;

  localparam int LPF_TAP    = 32;
  localparam int HPF_TAP    = 96;
  localparam int CLR_CYCLES = 2;
  localparam int TOTAL      = 2 * LPF_TAP + HPF_TAP;

  // Model phases and event kinds.
  localparam int P_IDLE = 0, P_LOAD = 1, P_CLR = 2, P_RUN = 3;
  localparam int K_X = 1, K_Y = 2, K_H = 3, K_CLR = 4, K_DONE = 5;

  logic        clk = 1'b0;
  logic        rst, start, abort, coef_valid, sample_valid;
  logic [31:0] coef_data;
  logic        coef_ready, we_lpf_x, we_lpf_y, we_htf, clr, stall, busy, done;
  logic [31:0] cr;

  always #5 clk = ~clk;

  filter_coef_sequencer #(
    .LPF_TAP(LPF_TAP), .HPF_TAP(HPF_TAP), .CNT_W(8), .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .coef_data(coef_data), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .sample_valid(sample_valid), .cr(cr), .we_lpf_x(we_lpf_x),
    .we_lpf_y(we_lpf_y), .we_htf(we_htf), .clr(clr), .stall(stall),
    .busy(busy), .done(done)
  );

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          stamp;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  // Reference model state: phase, words loaded, clr cycles issued.
  int m_phase = P_IDLE;
  int m_k = 0;
  int m_clr = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int filt(input int k);
    if (k < LPF_TAP) return K_X;
    else if (k < 2 * LPF_TAP) return K_Y;
    else return K_H;
  endfunction

  task automatic push_ev(input int kind, input logic [31:0] data, input int stamp);
    ev_t e;
    e.kind = kind; e.data = data; e.stamp = stamp;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe the DUT raises is matched against the scoreboard.
  always @(negedge clk) begin
    int   n_hi;
    int   kind;
    ev_t  e;
    n_hi = int'(we_lpf_x) + int'(we_lpf_y) + int'(we_htf) + int'(clr) + int'(done);
    if (n_hi != 0) begin
      chk("one_strobe", 32'(n_hi), 32'd1);
      kind = we_lpf_x ? K_X : we_lpf_y ? K_Y : we_htf ? K_H : clr ? K_CLR : K_DONE;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'(kind), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        chk("event_cycle", 32'(cyc), 32'(e.stamp));
        if (kind <= K_H) chk("cr_data", cr, e.data);
      end
    end
  end

  // Drive one cycle, check combinational outputs, advance the model, clock.
  task automatic step(input logic st, input logic ab, input logic v,
                      input logic [31:0] d, input logic sv, input logic r);
    int t;
    start = st; abort = ab; coef_valid = v; coef_data = d; sample_valid = sv; rst = r;
    #1;
    chk("coef_ready", 32'(coef_ready), 32'(m_phase == P_LOAD));
    chk("stall", 32'(stall), 32'(!(m_phase == P_RUN && sv)));
    chk("busy", 32'(busy), 32'(m_phase == P_LOAD || m_phase == P_CLR));
    t = cyc + 1;
    if (r || ab) begin
      m_phase = P_IDLE;
      m_k = 0;
    end else begin
      case (m_phase)
        P_IDLE, P_RUN: if (st) begin m_phase = P_LOAD; m_k = 0; end
        P_LOAD: if (v) begin
          push_ev(filt(m_k), d, t);
          m_k++;
          if (m_k == TOTAL) begin m_phase = P_CLR; m_clr = 0; end
        end
        P_CLR: if (m_clr < CLR_CYCLES) begin
          push_ev(K_CLR, 32'h0, t);
          m_clr++;
        end else begin
          push_ev(K_DONE, 32'h0, t);
          m_phase = P_RUN;
        end
        default: m_phase = P_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // mode 0: back-to-back words 1..160; 1: valid toggling; 2: random valid.
  task automatic load(input int mode);
    int          guard;
    logic        v;
    logic [31:0] d;
    guard = 0;
    while (m_phase == P_LOAD && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (mode == 0) ? 32'(m_k + 1) : $urandom;
      step(1'b0, 1'b0, v, d, 1'($urandom_range(0, 1)), 1'b0);
      guard++;
    end
    chk("load_finished", 32'(m_phase != P_LOAD), 32'd1);
  endtask

  task automatic feed_until(input int n);
    while (m_k < n && m_phase == P_LOAD)
      step(1'b0, 1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; coef_valid = 1'b0; coef_data = 32'h0;
    sample_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_phase = P_IDLE; m_k = 0;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_cr", cr, 32'h0);
    chk("rst_we_x", 32'(we_lpf_x), 32'd0);
    chk("rst_we_y", 32'(we_lpf_y), 32'd0);
    chk("rst_we_h", 32'(we_htf), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    chk("rst_ready", 32'(coef_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    idle(3);

    // Full back-to-back load with sequential data.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    load(0);
    idle(10);

    // Reload from RUN with toggling valid; start during CLR is ignored.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    load(1);
    step(1'b1, 1'b0, 1'b1, $urandom, 1'b1, 1'b0);
    idle(8);

    // Abort right after the 40th accept, coef_valid still high.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    feed_until(40);
    step(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    load(2);
    idle(6);

    // Synchronous reset in the middle of the Hilbert load, then reload.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    feed_until(100);
    step(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b1);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    load(2);
    idle(8);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
